// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans OAM at each line_start and copies the first
// MAX_PER_LINE covering sprites into the line slots. Optional macro: SPRITE_OVERFLOW_SCAN_EN.
//
//   state | meaning
//   IDLE  | waiting for line_start
//   CLEAR | invalidate slots, reset read index
//   SCAN  | issue one OAM read per cycle, evaluate previous read
//   DRAIN | evaluate final returned entry
//   DONE  | pulse line_done
module sprite_line_scheduler #(
  parameter int SPRITE_NUM   = 64,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_H     = 8,
  parameter int POS_W        = 10
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              line_start,
  input  logic [POS_W-1:0]                  line_y,
  output logic                              oam_rd_en,
  output logic [$clog2(SPRITE_NUM)-1:0]     oam_addr,
  input  logic [31:0]                       oam_data,
  output logic                              slot_we,
  output logic [$clog2(MAX_PER_LINE)-1:0]   slot_idx,
  output logic [31:0]                       slot_data,
  output logic [$clog2(SPRITE_H)-1:0]       slot_row,
  output logic                              slot_clr,
  output logic [$clog2(MAX_PER_LINE):0]     sprite_cnt,
  output logic                              busy,
  output logic                              line_done,
  output logic                              overflow
);

  localparam int AW = $clog2(SPRITE_NUM);
  localparam int SW = $clog2(MAX_PER_LINE);
  localparam int RW = $clog2(SPRITE_H);
  localparam int CW = SW + 1;
  localparam int YW = POS_W + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(SPRITE_NUM - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PER_LINE);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PER_LINE - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [POS_W-1:0] ly;
  logic [AW-1:0]   idx;
  logic            rd_vld;
  logic [CW-1:0]   cnt;

  logic [YW-1:0]   ly_ext, py_ext, py_top, row_full;
  logic            hit, eval, room, wr;

  // Hit test is done one bit wider than the line coordinate so posY+SPRITE_H never wraps.
  assign ly_ext   = {1'b0, ly};
  assign py_ext   = YW'(oam_data[23:16]);
  assign py_top   = py_ext + YW'(SPRITE_H);
  assign row_full = ly_ext - py_ext;
  assign hit      = (ly_ext >= py_ext) && (ly_ext < py_top);

  // A restarting line_start suppresses any write due from the aborted scan.
  assign eval = rd_vld && ((state == S_SCAN) || (state == S_DRAIN)) && !line_start;
  assign room = (cnt < CNT_MAX);
  assign wr   = eval && hit && room;

  assign sprite_cnt = cnt;

`ifdef SPRITE_OVERFLOW_SCAN_EN
  logic ovf, ovf_set;
  assign ovf_set  = eval && hit && !room;
  assign overflow = ovf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (line_start) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      ly     <= '0;
      idx    <= '0;
      rd_vld <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      rd_vld <= oam_rd_en;
      if (state == S_CLEAR) begin
        idx <= '0;
      end else if (oam_rd_en) begin
        idx <= idx + AW'(1);
      end
      if (line_start) begin
        ly  <= line_y;
        cnt <= '0;
      end else if (wr) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    oam_rd_en = 1'b0;
    oam_addr  = '0;
    slot_we   = 1'b0;
    slot_idx  = '0;
    slot_data = '0;
    slot_row  = '0;
    slot_clr  = 1'b0;
    busy      = 1'b0;
    line_done = 1'b0;

    case (state)
      S_IDLE: ;
      S_CLEAR: begin
        slot_clr  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_SCAN;
      end
      S_SCAN: begin
        busy      = 1'b1;
        oam_rd_en = 1'b1;
        oam_addr  = idx;
        if (idx == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        line_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (wr) begin
      slot_we   = 1'b1;
      slot_idx  = cnt[SW-1:0];
      slot_data = oam_data;
      slot_row  = row_full[RW-1:0];
`ifndef SPRITE_OVERFLOW_SCAN_EN
      // Slots just filled: stop issuing reads; the read already in flight is ignored.
      if ((cnt == CNT_LAST) && (state == S_SCAN)) state_nxt = S_DRAIN;
`endif
    end

    if (line_start) state_nxt = S_CLEAR;
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: single sprite, Y boundaries, overflow,
// abort, async reset mid-scan and back-to-back lines.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic        oam_rd_en;
  logic [5:0]  oam_addr;
  logic [31:0] oam_data = '0;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [31:0] slot_data;
  logic [2:0]  slot_row;
  logic        slot_clr;
  logic [3:0]  sprite_cnt;
  logic        busy;
  logic        line_done;
  logic        overflow;

  sprite_line_scheduler dut (
    .clk(clk), .rstn(rstn), .line_start(line_start), .line_y(line_y),
    .oam_rd_en(oam_rd_en), .oam_addr(oam_addr), .oam_data(oam_data),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_data(slot_data), .slot_row(slot_row),
    .slot_clr(slot_clr), .sprite_cnt(sprite_cnt), .busy(busy),
    .line_done(line_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [31:0] oam [64];
  always @(posedge clk) if (oam_rd_en) oam_data <= oam[oam_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_wr, n_clr, n_done, done_cyc, rd_exp, addr_bad;
  logic [2:0]  wr_idx  [32];
  logic [31:0] wr_data [32];
  logic [2:0]  wr_row  [32];

  always @(negedge clk) if (rstn) begin
    if (slot_we && n_wr < 32) begin
      wr_idx[n_wr]  = slot_idx;
      wr_data[n_wr] = slot_data;
      wr_row[n_wr]  = slot_row;
      n_wr++;
    end
    if (slot_clr) n_clr++;
    if (line_done) begin n_done++; done_cyc = cyc; end
    if (oam_rd_en) begin
      if (int'(oam_addr) != rd_exp) addr_bad++;
      rd_exp++;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_wr = 0; n_clr = 0; n_done = 0; done_cyc = 0; rd_exp = 0; addr_bad = 0;
  endtask

  // Pulse line_start for line y, wait (bounded) for line_done, return latency.
  task automatic run_line(input logic [9:0] y, output int lat);
    int t0;
    @(posedge clk); #1;
    clr_mon();
    line_y = y; line_start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 0; k < 200 && n_done == 0; k++) begin @(posedge clk); #1; end
    repeat (3) @(posedge clk);
    #1;
    lat = done_cyc - t0;
  endtask

  int lat, t1;

  initial begin
    for (int i = 0; i < 64; i++) oam[i] = 32'h00F0_0000;
    oam[0] = 32'h0A0A_0280;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", oam_rd_en, 0);
    chk("rst_slot_we", slot_we, 0);
    chk("rst_slot_clr", slot_clr, 0);
    chk("rst_done", line_done, 0);
    chk("rst_cnt", sprite_cnt, 0);
    chk("rst_ovf", overflow, 0);
    rstn = 1'b1;

    run_line(10'd12, lat);
    chk("single_nwr", n_wr, 1);
    chk("single_idx", wr_idx[0], 0);
    chk("single_data", wr_data[0], 32'h0A0A_0280);
    chk("single_row", wr_row[0], 2);
    chk("single_cnt", sprite_cnt, 1);
    chk("single_lat", lat, 67);
    chk("single_clr", n_clr, 1);
    chk("single_ndone", n_done, 1);
    chk("single_nrd", rd_exp, 64);
    chk("single_addr_seq", addr_bad, 0);
    chk("single_busy_end", busy, 0);

    // Overflow: indices 3..12 all at posY=20
    for (int i = 3; i <= 12; i++) oam[i] = {8'(i), 8'd20, 8'(i + 16), 8'h00};
    run_line(10'd20, lat);
    chk("ovf_nwr", n_wr, 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_idx%0d", k), wr_idx[k], k);
      chk($sformatf("ovf_data%0d", k), wr_data[k], {8'(k + 3), 8'd20, 8'(k + 19), 8'h00});
    end
    chk("ovf_cnt", sprite_cnt, 8);
`ifdef SPRITE_OVERFLOW_SCAN_EN
    chk("ovf_flag", overflow, 1);
    chk("ovf_lat", lat, 67);
`else
    chk("ovf_flag", overflow, 0);
    chk("ovf_lat_short", (lat > 0 && lat < 67), 1);
`endif
    for (int i = 3; i <= 12; i++) oam[i] = 32'h00F0_0000;

    run_line(10'd9, lat);
    chk("y9_nwr", n_wr, 0);
    chk("y9_cnt", sprite_cnt, 0);
    chk("y9_ovf_cleared", overflow, 0);
    run_line(10'd10, lat);
    chk("y10_nwr", n_wr, 1);
    chk("y10_row", wr_row[0], 0);
    run_line(10'd17, lat);
    chk("y17_nwr", n_wr, 1);
    chk("y17_row", wr_row[0], 7);
    run_line(10'd18, lat);
    chk("y18_nwr", n_wr, 0);
    chk("y18_cnt", sprite_cnt, 0);
    chk("y18_lat", lat, 67);

    // Abort: second line_start 20 cycles into the scan of line 12
    oam[5] = 32'h1128_0301;
    @(posedge clk); #1;
    clr_mon();
    line_y = 10'd12; line_start = 1'b1; t1 = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
    while (cyc - t1 < 20) begin @(posedge clk); #1; end
    chk("abort_busy", busy, 1);
    chk("abort_old_wr", n_wr, 1);
    n_wr = 0;
    line_y = 10'd40; line_start = 1'b1; t1 = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 0; k < 200 && n_done == 0; k++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #1;
    chk("abort_nclr", n_clr, 2);
    chk("abort_ndone", n_done, 1);
    chk("abort_lat", done_cyc - t1, 67);
    chk("abort_nwr", n_wr, 1);
    chk("abort_data", wr_data[0], 32'h1128_0301);
    chk("abort_row", wr_row[0], 0);
    chk("abort_cnt", sprite_cnt, 1);

    // Async reset mid-SCAN
    @(posedge clk); #1;
    clr_mon();
    line_y = 10'd12; line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", oam_rd_en, 0);
    chk("arst_cnt", sprite_cnt, 0);
    chk("arst_slot_data", slot_data, 0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("arst_idle", busy, 0);
    run_line(10'd12, lat);
    chk("arst_after_nwr", n_wr, 1);
    chk("arst_after_data", wr_data[0], 32'h0A0A_0280);
    chk("arst_after_lat", lat, 67);

    // Back-to-back: second line_start coincides with DONE
    @(posedge clk); #1;
    clr_mon();
    line_y = 10'd12; line_start = 1'b1; t1 = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 0; k < 200 && line_done !== 1'b1; k++) begin @(posedge clk); #1; end
    chk("b2b_first_lat", cyc - t1, 67);
    chk("b2b_cnt_hold", sprite_cnt, 1);
    n_wr = 0;
    line_y = 10'd40; line_start = 1'b1; t1 = cyc;
    @(posedge clk); #1;
    line_start = 1'b0;
    chk("b2b_first_done", n_done, 1);
    chk("b2b_clr_now", slot_clr, 1);
    chk("b2b_busy_now", busy, 1);
    chk("b2b_cnt_clr", sprite_cnt, 0);
    for (int k = 0; k < 200 && n_done < 2; k++) begin @(posedge clk); #1; end
    chk("b2b_ndone", n_done, 2);
    chk("b2b_second_lat", done_cyc - t1, 67);
    chk("b2b_nwr", n_wr, 1);
    chk("b2b_data", wr_data[0], 32'h1128_0301);
    chk("b2b_cnt", sprite_cnt, 1);
    chk("b2b_ovf", overflow, 0);
    chk("b2b_nclr", n_clr, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluator for the PPU. At each line-start pulse it scans the sprite attribute table (OAM) and copies the first MAX_PER_LINE sprites that cover the requested line into the line-slot buffer, which feeds the tileDraw units.
- Sits between OAM and the tileDraw units, in the 100 MHz compute domain, ahead of the 25 MHz VGA scan.
- Sequences OAM reads. Reports the slot count, completion and overflow.

Parameters:
- SPRITE_NUM, 64, number of OAM entries scanned.
- MAX_PER_LINE, 8, number of line slots.
- SPRITE_H, 8, sprite height in pixels.
- POS_W, 10, width of the line coordinate (matches `VGA_POSXY_BIT).

Ports:
- clk  in  1  compute clock (100 MHz)
- rstn  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse; begin evaluating line_y
- line_y  in  POS_W  line to evaluate; sampled when line_start=1
- oam_rd_en  out  1  OAM read strobe
- oam_addr  out  clog2(SPRITE_NUM)  OAM entry index
- oam_data  in  32  entry data, valid the cycle after oam_rd_en; format [31:24] posX, [23:16] posY, [15:8] tileIndex, [7:0] attr
- slot_we  out  1  slot write strobe
- slot_idx  out  clog2(MAX_PER_LINE)  slot written
- slot_data  out  32  copied OAM entry
- slot_row  out  clog2(SPRITE_H)  row within sprite, = line_y - posY
- slot_clr  out  1  one-cycle pulse; the consumer invalidates all slots
- sprite_cnt  out  clog2(MAX_PER_LINE)+1  hits stored this line
- busy  out  1  scan in progress
- line_done  out  1  one-cycle pulse at end of scan
- overflow  out  1  more than MAX_PER_LINE hits on the last line

Behaviour:
- Reset (async, rstn=0): state IDLE; every output = 0.
- States: IDLE -> CLEAR -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - line_start=1: latch line_y into ly; clear sprite_cnt; clear overflow; go to CLEAR.
- CLEAR (1 cycle):
  - slot_clr=1, busy=1; read index i=0.
- SCAN (pipelined, one entry per clk):
  - Each cycle: oam_rd_en=1, oam_addr=i, i++.
  - The entry returned from the previous cycle's read is evaluated in the same cycle.
  - After issuing i=SPRITE_NUM-1, go to DRAIN.
- DRAIN (1 cycle):
  - Evaluate the last returned entry; no read issued.
- Hit test, at POS_W+1 bits with posY zero-extended and no wrap:
  - hit = (ly >= posY) && (ly < posY + SPRITE_H).
- On a hit with sprite_cnt < MAX_PER_LINE:
  - slot_we=1, slot_idx=sprite_cnt, slot_data=oam_data, slot_row=(ly-posY)[clog2(SPRITE_H)-1:0]; sprite_cnt++.
- On a hit with sprite_cnt == MAX_PER_LINE:
  - See the optional feature; no slot write.
- Priority: lower OAM index wins; slots are filled in ascending index order.
- DONE (1 cycle):
  - line_done=1, busy=0; go to IDLE.
  - sprite_cnt and overflow hold until the next line_start.
- Latency: line_start to line_done = SPRITE_NUM+3 cycles (full scan).
- line_start while busy:
  - Abort, relatch line_y, restart at CLEAR.
  - No line_done for the aborted line.
  - A slot write due in that same cycle is suppressed.
- line_start coincident with DONE: line_done still pulses; the new line begins at CLEAR next cycle.
- busy = 1 in CLEAR, SCAN and DRAIN.

Optional Feature:
- Macro: SPRITE_OVERFLOW_SCAN_EN.
- Defined:
  - After the slots fill, the scan continues to the last entry.
  - overflow is set on the first further hit and is sticky for the line.
  - Latency is fixed at SPRITE_NUM+3.
- Undefined:
  - Once sprite_cnt reaches MAX_PER_LINE the block enters DRAIN immediately. The in-flight read is discarded.
  - overflow is held at 0.
  - Latency is variable, ≤ SPRITE_NUM+3.

Test Plan:
- Single sprite: OAM[0]=32'h0A0A0280, others posY=8'hF0. line_start with line_y=12 -> exactly one slot_we, slot_idx=0, slot_data=32'h0A0A0280, slot_row=2, sprite_cnt=1, line_done at cycle 67 (SPRITE_NUM=64).
- Y boundaries, same OAM: line_y=9 -> no write, sprite_cnt=0. line_y=10 -> slot_row=0. line_y=17 -> slot_row=7. line_y=18 -> no write.
- Overflow: 10 entries with posY=20 at indices 3..12, line_y=20.
  - All builds: slots 0..7 get indices 3..10, sprite_cnt=8.
  - With SPRITE_OVERFLOW_SCAN_EN: overflow=1, line_done at cycle 67.
  - Without it: overflow=0, line_done earlier than cycle 67.
- Abort: line_start (line_y=12) then a second line_start (line_y=40) 20 cycles later -> one slot_clr per start, only one line_done, slots reflect line 40 only.
- Async reset mid-SCAN: rstn low for 3 cycles -> all outputs 0 immediately, state IDLE. A following line_start scans normally.
- Back-to-back lines: line_start re-asserted in the DONE cycle -> line_done pulses, the next scan starts without an idle gap, and sprite_cnt/overflow clear for the new line.
